// File: rtl/wb_init_pkg.sv
`default_nettype none
// ============================================================================
// Package : wb_init_pkg
// Brief   : Shared state, response-status types and sizing helper for the
//           Wishbone host initiator.
// Revision: 1.0
// ============================================================================
package wb_init_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic timeout;
      logic err;
   } rsp_status_t;

   // Counter only ever reaches TIMEOUT-1; keep one bit when the timeout is disabled.
   function automatic int cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wb_rsp_fifo
// Brief   : Small synchronous first-word-fall-through FIFO for responses.
// Revision: 1.0
// ============================================================================
module wb_rsp_fifo #(
   parameter int W  = 34,
   parameter int DP = 2
) (
   input  logic                    wbm_clk_i,
   input  logic                    wbm_rst_n,
   input  logic                    push,
   input  logic [W-1:0]            push_dat,
   input  logic                    pop,
   output logic [W-1:0]            pop_dat,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DP+1)-1:0] count
);

   localparam int            PW   = (DP > 1) ? $clog2(DP) : 1;
   localparam int            CW   = $clog2(DP + 1);
   localparam logic [CW-1:0] c_DP = CW'(DP);

   logic [W-1:0]  r_mem [DP];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign w_do_push = push && (r_count != c_DP);
   assign w_do_pop  = pop && (r_count != '0);

   // DP is a power of two, so the pointers wrap naturally.
   always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
      if (!wbm_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge wbm_clk_i) begin
      if (w_do_push) r_mem[r_wr_ptr] <= push_dat;
   end

   assign pop_dat = r_mem[r_rd_ptr];
   assign full    = (r_count == c_DP);
   assign empty   = (r_count == '0);
   assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/wb_host_initiator.sv
`default_nettype none
// ============================================================================
// Module  : wb_host_initiator
// Brief   : Wishbone classic single-transfer initiator with a buffered
//           valid/ready response stream and optional strobe timeout.
// Revision: 1.0
// ============================================================================
module wb_host_initiator
   import wb_init_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int BW      = 4,
   parameter int TIMEOUT = 1024,
   parameter int RSP_DP  = 2
) (
   input  logic          wbm_clk_i,
   input  logic          wbm_rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [AW-1:0] req_adr,
   input  logic [DW-1:0] req_dat,
   input  logic [BW-1:0] req_sel,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_dat,
   output logic          rsp_err,
   output logic          rsp_timeout,
   output logic          busy,
   output logic          wbm_cyc_o,
   output logic          wbm_stb_o,
   output logic [AW-1:0] wbm_adr_o,
   output logic          wbm_we_o,
   output logic [DW-1:0] wbm_dat_o,
   output logic [BW-1:0] wbm_sel_o,
   input  logic [DW-1:0] wbm_dat_i,
   input  logic          wbm_ack_i,
   input  logic          wbm_err_i
);

   localparam int               CNT_W     = cnt_width(TIMEOUT);
   localparam int               FCW       = $clog2(RSP_DP + 1);
   localparam logic             c_TO_EN   = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] c_TO_LAST = (TIMEOUT != 0) ? CNT_W'(TIMEOUT - 1) : '0;
   localparam logic [FCW-1:0]   c_RSP_DP  = FCW'(RSP_DP);

   typedef struct packed {
      rsp_status_t   st;
      logic [DW-1:0] dat;
   } rsp_t;

   localparam int RW = $bits(rsp_t);

   state_e           r_state;
   state_e           w_state_nxt;
   logic             r_cyc;
   logic             r_stb;
   logic             r_we;
   logic [AW-1:0]    r_adr;
   logic [DW-1:0]    r_dat;
   logic [BW-1:0]    r_sel;
   logic [CNT_W-1:0] r_cnt;

   logic             w_req_fire;
   logic             w_term_err;
   logic             w_term_ack;
   logic             w_term_to;
   logic             w_term;
   logic             w_rsp_push;
   logic             w_rsp_pop;
   rsp_t             w_push_rsp;
   rsp_t             w_head;
   logic [RW-1:0]    w_head_raw;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic [FCW-1:0]   w_fifo_count;

   // r_stb is only ever set in BUS, so these terms are implicitly gated by state.
   assign w_term_err = r_stb & wbm_err_i;
   assign w_term_ack = r_stb & wbm_ack_i & ~wbm_err_i;
   assign w_term_to  = r_stb & c_TO_EN & ~wbm_ack_i & ~wbm_err_i & (r_cnt == c_TO_LAST);
   assign w_term     = w_term_err | w_term_ack | w_term_to;
   assign w_req_fire = req_valid & req_ready;

   always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
      if (!wbm_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 1'b0;
      busy        = (r_state != IDLE);
      unique case (r_state)
         IDLE: begin
            req_ready = (w_fifo_count < c_RSP_DP);
            if (req_valid && req_ready) w_state_nxt = BUS;
         end
         BUS: begin
            if (w_term) w_state_nxt = DONE;
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
      if (!wbm_rst_n) begin
         r_cyc <= 1'b0;
         r_stb <= 1'b0;
         r_we  <= 1'b0;
         r_adr <= '0;
         r_dat <= '0;
         r_sel <= '0;
         r_cnt <= '0;
      end else begin
         if (w_req_fire) begin
            r_cyc <= 1'b1;
            r_stb <= 1'b1;
            r_we  <= req_we;
            r_adr <= req_adr;
            r_dat <= req_dat;
            r_sel <= req_sel;
            r_cnt <= '0;
         end else if (w_term) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
         end else if (r_stb && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Data is returned only for an acknowledged read; every other outcome carries zero.
   always_comb begin
      w_push_rsp            = '0;
      w_push_rsp.st.timeout = w_term_to;
      w_push_rsp.st.err     = w_term_err | w_term_to;
      if (w_term_ack && !r_we) w_push_rsp.dat = wbm_dat_i;
   end

   assign w_rsp_push = w_term & ~w_fifo_full;
   assign w_rsp_pop  = rsp_valid & rsp_ready;

   wb_rsp_fifo #(
      .W  (RW),
      .DP (RSP_DP)
   ) u_rsp_fifo (
      .wbm_clk_i (wbm_clk_i),
      .wbm_rst_n (wbm_rst_n),
      .push      (w_rsp_push),
      .push_dat  (w_push_rsp),
      .pop       (w_rsp_pop),
      .pop_dat   (w_head_raw),
      .full      (w_fifo_full),
      .empty     (w_fifo_empty),
      .count     (w_fifo_count)
   );

   assign w_head      = w_head_raw;
   assign rsp_valid   = ~w_fifo_empty;
   assign rsp_dat     = w_head.dat;
   assign rsp_err     = w_head.st.err;
   assign rsp_timeout = w_head.st.timeout;

   assign wbm_cyc_o = r_cyc;
   assign wbm_stb_o = r_stb;
   assign wbm_adr_o = r_adr;
   assign wbm_we_o  = r_we;
   assign wbm_dat_o = r_dat;
   assign wbm_sel_o = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_wb_host_initiator.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_host_initiator
// Brief   : Directed and randomized self-checking bench for wb_host_initiator.
// Revision: 1.0
// ============================================================================
module tb_wb_host_initiator;

   localparam int TO     = 16;
   localparam int K_ACK  = 0;
   localparam int K_ERR  = 1;
   localparam int K_BOTH = 2;
   localparam int K_NONE = 3;

   logic        wbm_clk_i = 1'b0;
   logic        wbm_rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we    = 1'b0;
   logic [31:0] req_adr   = '0;
   logic [31:0] req_dat   = '0;
   logic [3:0]  req_sel   = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_dat;
   logic        rsp_err;
   logic        rsp_timeout;
   logic        busy;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic [31:0] wbm_adr_o;
   logic        wbm_we_o;
   logic [31:0] wbm_dat_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_dat_i = '0;
   logic        wbm_ack_i = 1'b0;
   logic        wbm_err_i = 1'b0;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_fail   = 0;
   logic [33:0] exp_q[$];

   always #5 wbm_clk_i = ~wbm_clk_i;

   wb_host_initiator #(
      .AW(32), .DW(32), .BW(4), .TIMEOUT(TO), .RSP_DP(2)
   ) dut (
      .wbm_clk_i   (wbm_clk_i),
      .wbm_rst_n   (wbm_rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_adr     (req_adr),
      .req_dat     (req_dat),
      .req_sel     (req_sel),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_dat     (rsp_dat),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .busy        (busy),
      .wbm_cyc_o   (wbm_cyc_o),
      .wbm_stb_o   (wbm_stb_o),
      .wbm_adr_o   (wbm_adr_o),
      .wbm_we_o    (wbm_we_o),
      .wbm_dat_o   (wbm_dat_o),
      .wbm_sel_o   (wbm_sel_o),
      .wbm_dat_i   (wbm_dat_i),
      .wbm_ack_i   (wbm_ack_i),
      .wbm_err_i   (wbm_err_i)
   );

   task automatic tick();
      @(posedge wbm_clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference outcome {timeout, err, dat}: a responder that answers after the
   // timeout window is never seen, and err always beats ack.
   function automatic logic [33:0] model_rsp(input logic we, input int kind, input int lat,
                                             input logic [31:0] rdat);
      if (kind == K_NONE || lat > TO) return {2'b11, 32'h0};
      if (kind == K_ERR || kind == K_BOTH) return {2'b01, 32'h0};
      return {2'b00, (we ? 32'h0 : rdat)};
   endfunction

   // One full transfer: request, slave answers in stb-high cycle 'lat' (if any).
   task automatic do_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int kind, input int lat,
                          input logic [31:0] rdat, output int waited);
      int   n;
      int   exp_len;
      logic stable;
      req_valid = 1'b1;
      req_we    = we;
      req_adr   = adr;
      req_dat   = dat;
      req_sel   = sel;
      waited    = 0;
      while (req_ready !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      check("req_ready", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      req_we    = ~we;
      req_adr   = $urandom;
      req_dat   = $urandom;
      req_sel   = 4'($urandom);
      check("stb_rise", {wbm_cyc_o, wbm_stb_o}, 2'b11);
      check("wb_adr", wbm_adr_o, adr);
      check("wb_we_sel_dat", {wbm_we_o, wbm_sel_o, wbm_dat_o}, {we, sel, dat});
      exp_len = (kind == K_NONE || lat > TO) ? TO : lat;
      stable  = 1'b1;
      n       = 0;
      while (wbm_stb_o === 1'b1 && n < 40) begin
         n++;
         if (kind != K_NONE && n == lat) begin
            wbm_ack_i = (kind != K_ERR);
            wbm_err_i = (kind != K_ACK);
            wbm_dat_i = rdat;
         end
         tick();
         wbm_ack_i = 1'b0;
         wbm_err_i = 1'b0;
         wbm_dat_i = $urandom;
         if (wbm_stb_o === 1'b1)
            stable &= (wbm_adr_o === adr) && (wbm_dat_o === dat) && (wbm_sel_o === sel)
                      && (wbm_we_o === we) && (wbm_cyc_o === 1'b1);
      end
      check("fields_stable", stable, 1'b1);
      check("stb_len", n, exp_len);
      check("done_state", {wbm_cyc_o, busy, req_ready}, 3'b010);
      exp_q.push_back(model_rsp(we, kind, lat, rdat));
   endtask

   task automatic pop_rsp(input string tag);
      int          w;
      logic [33:0] exp;
      w = 0;
      while (rsp_valid !== 1'b1 && w < 40) begin
         tick();
         w++;
      end
      check({tag, "_valid"}, rsp_valid, 1'b1);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h0;
      check(tag, {rsp_timeout, rsp_err, rsp_dat}, exp);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          waited;
      int          kind;
      int          lat;
      logic        we;
      logic        stall_ok;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] r;
      logic [3:0]  s;

      // Reset values
      tick();
      tick();
      check("rst_ctl", {wbm_cyc_o, wbm_stb_o, wbm_we_o, busy, rsp_valid}, 5'b0);
      check("rst_adr", wbm_adr_o, 32'h0);
      check("rst_dat_sel", {wbm_sel_o, wbm_dat_o}, 36'h0);
      wbm_rst_n = 1'b1;
      tick();
      check("idle_ready", req_ready, 1'b1);

      // Directed write, ack in the 4th strobe cycle
      do_xfer(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, K_ACK, 4, 32'h5555_AAAA, waited);
      tick();
      check("busy_low", busy, 1'b0);
      pop_rsp("wr_rsp");

      // Directed reads, back to back
      do_xfer(1'b0, 32'h2000_0000, 32'h0BAD_F00D, 4'hF, K_ACK, 2, 32'h1234_5678, waited);
      do_xfer(1'b0, 32'h2000_0004, 32'h0, 4'h3, K_ACK, 1, 32'hCAFE_0001, waited);
      check("b2b_gap", waited, 1);
      pop_rsp("rd_rsp0");
      pop_rsp("rd_rsp1");

      // Simultaneous ack+err, timeout, and ack on the last timeout cycle
      do_xfer(1'b0, 32'h3000_0000, 32'h0, 4'h1, K_BOTH, 3, 32'hFFFF_FFFF, waited);
      pop_rsp("both_rsp");
      do_xfer(1'b1, 32'h4000_0000, 32'h7777_7777, 4'hC, K_NONE, 1, 32'h0, waited);
      pop_rsp("to_rsp");
      do_xfer(1'b0, 32'h4000_0008, 32'h0, 4'hF, K_ACK, TO, 32'hA5A5_5A5A, waited);
      pop_rsp("ack16_rsp");

      // Response FIFO back-pressure
      do_xfer(1'b0, 32'h5000_0000, 32'h0, 4'hF, K_ACK, 2, 32'h1111_1111, waited);
      do_xfer(1'b0, 32'h5000_0004, 32'h0, 4'hF, K_ACK, 1, 32'h2222_2222, waited);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_adr   = 32'h5000_0008;
      stall_ok  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         stall_ok &= (req_ready === 1'b0) && (wbm_stb_o === 1'b0);
      end
      check("full_stall", stall_ok, 1'b1);
      pop_rsp("full_rsp0");
      check("full_ready", req_ready, 1'b1);
      do_xfer(1'b0, 32'h5000_0008, 32'h0, 4'hF, K_ACK, 3, 32'h3333_3333, waited);
      pop_rsp("full_rsp1");
      pop_rsp("full_rsp2");

      // Randomized transfers against the reference model
      for (int t = 0; t < 40; t++) begin
         if (exp_q.size() >= 2) pop_rsp("rnd_rsp");
         kind = int'($urandom_range(0, 3));
         lat  = int'($urandom_range(1, TO + 2));
         we   = 1'($urandom_range(0, 1));
         a    = $urandom;
         d    = $urandom;
         r    = $urandom;
         s    = 4'($urandom);
         do_xfer(we, a, d, s, kind, lat, r, waited);
         if ($urandom_range(0, 1) == 1) pop_rsp("rnd_rsp");
      end
      while (exp_q.size() > 0) pop_rsp("drain_rsp");

      // Terminations while stb is low must be ignored
      wbm_ack_i = 1'b1;
      wbm_err_i = 1'b1;
      tick();
      tick();
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      tick();
      check("idle_ack_ignored", {rsp_valid, wbm_stb_o, busy}, 3'b000);

      // Asynchronous reset in the middle of a bus cycle
      do_xfer(1'b1, 32'h6000_0000, 32'h1234_0000, 4'hF, K_ACK, 1, 32'h0, waited);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_adr   = 32'h6000_0004;
      waited    = 0;
      while (req_ready !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      tick();
      req_valid = 1'b0;
      repeat (4) tick();
      check("pre_rst_stb", {wbm_stb_o, rsp_valid}, 2'b11);
      #2;
      wbm_rst_n = 1'b0;
      #1;
      check("async_rst", {wbm_cyc_o, wbm_stb_o, rsp_valid, busy}, 4'b0);
      exp_q.delete();
      tick();
      tick();
      wbm_rst_n = 1'b1;
      tick();
      check("post_rst", {rsp_valid, req_ready}, 2'b01);
      do_xfer(1'b0, 32'h7000_0000, 32'h0, 4'hF, K_ACK, 2, 32'h9876_5432, waited);
      pop_rsp("post_rst_rsp");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
